// File: rtl/cache_pkg.sv
// cache_pkg
// Shared address-split helpers for the data cache. The controller and the tag/data array
// use the same functions so both sides agree on way/set/tag field widths.
//   way_size(num_ways)                 : bits needed to name a way
//   set_size(num_sets)                 : bits needed to name a set
//   tag_size(addr, num_sets, block)    : tag bits left after set index and block offset
package cache_pkg;

   localparam int unsigned DefAddrSize  = 32;
   localparam int unsigned DefNumSets   = 4;
   localparam int unsigned DefNumWays   = 2;
   localparam int unsigned DefBlockSize = 32;

   function automatic int unsigned way_size(input int unsigned num_ways);
      return $clog2(num_ways);
   endfunction

   function automatic int unsigned set_size(input int unsigned num_sets);
      return $clog2(num_sets);
   endfunction

   // Block offset is counted in bytes: BLOCK_SIZE bits / 8 bits per byte, addressed as
   // BLOCK_SIZE/4 in the cache's address map.
   function automatic int unsigned tag_size(input int unsigned addr_size,
                                            input int unsigned num_sets,
                                            input int unsigned block_size);
      return addr_size - $clog2(num_sets) - $clog2(block_size / 4);
   endfunction

   // One cache line with the default geometry.
   typedef struct packed {
      logic                                                         valid;
      logic [tag_size(DefAddrSize, DefNumSets, DefBlockSize)-1:0]   tag;
      logic [DefBlockSize-1:0]                                      data;
   } line_t;

endpackage

// File: rtl/cache_way_select.sv
// cache_way_select
// Picks the lowest-index way whose bit in valid_i is 0; if every bit is set, falls back to
// fifo_ptr_i. Used for fill-way selection (valid vector) and, fed with ~hit, as the hit-way
// encoder.
//   valid_i    : per-way flag, 0 marks a candidate
//   fifo_ptr_i : fallback way when no candidate exists
//   way_o      : selected way
module cache_way_select #(
   parameter int unsigned NUM_WAYS = 2,
   parameter int unsigned WaySize  = 1
) (
   input  logic [NUM_WAYS-1:0] valid_i,
   input  logic [WaySize-1:0]  fifo_ptr_i,
   output logic [WaySize-1:0]  way_o
);

   always_comb begin
      way_o = fifo_ptr_i;
      // Walk downward so the lowest free index is the last one assigned.
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!valid_i[i]) begin
            way_o = WaySize'(i);
         end
      end
   end

endmodule

// File: rtl/cache_mem.sv
// cache_mem
// Tag/data/valid storage for a set-associative data cache, with combinational lookup and
// fill-way suggestion (first invalid way, else per-set round-robin pointer).
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-low reset, clears valid bits and round-robin pointers
//   write_way    : way written when write_enable is high
//   set          : set index for lookup and write
//   tag          : lookup tag, also the tag stored on write
//   write_enable : write strobe
//   write_data   : line data to store
//   read_data    : data of lowest-index hitting way, 0 on miss
//   read_valid   : hit indicator
//   populate_way : way the controller should fill for set
module cache_mem
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_SIZE  = 32,
   parameter int unsigned NUM_SETS   = 4,
   parameter int unsigned NUM_WAYS   = 2,
   parameter int unsigned BLOCK_SIZE = 32
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [way_size(NUM_WAYS)-1:0]                       write_way,
   input  logic [set_size(NUM_SETS)-1:0]                       set,
   input  logic [tag_size(ADDR_SIZE, NUM_SETS, BLOCK_SIZE)-1:0] tag,
   input  logic                                                write_enable,
   input  logic [BLOCK_SIZE-1:0]                               write_data,
   output logic [BLOCK_SIZE-1:0]                               read_data,
   output logic                                                read_valid,
   output logic [way_size(NUM_WAYS)-1:0]                       populate_way
);

   localparam int unsigned WaySize = way_size(NUM_WAYS);
   localparam int unsigned SetSize = set_size(NUM_SETS);
   localparam int unsigned TagSize = tag_size(ADDR_SIZE, NUM_SETS, BLOCK_SIZE);

   logic [NUM_WAYS-1:0]   valid_q    [NUM_SETS];
   logic [NUM_WAYS-1:0]   valid_d    [NUM_SETS];
   logic [WaySize-1:0]    fifo_ptr_q [NUM_SETS];
   logic [WaySize-1:0]    fifo_ptr_d [NUM_SETS];
   logic [TagSize-1:0]    tag_q      [NUM_SETS][NUM_WAYS];
   logic [BLOCK_SIZE-1:0] data_q     [NUM_SETS][NUM_WAYS];

   logic [NUM_WAYS-1:0]   hit;
   logic [WaySize-1:0]    hit_way;

   // Next state for the resettable bookkeeping.
   always_comb begin
      valid_d    = valid_q;
      fifo_ptr_d = fifo_ptr_q;
      if (write_enable) begin
         valid_d[set][write_way] = 1'b1;
         // Pointer only advances when the fill lands on it, so out-of-order fills of free
         // ways do not disturb round-robin order.
         if (write_way == fifo_ptr_q[set]) begin
            fifo_ptr_d[set] = fifo_ptr_q[set] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s]    <= '0;
            fifo_ptr_q[s] <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         fifo_ptr_q <= fifo_ptr_d;
      end
   end

   // Tag and data need no reset; valid gates their use.
   always_ff @(posedge clk) begin
      if (rst && write_enable) begin
         tag_q[set][write_way]  <= tag;
         data_q[set][write_way] <= write_data;
      end
   end

   always_comb begin
      hit = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         hit[w] = valid_q[set][w] && (tag_q[set][w] == tag);
      end
   end

   // Lowest hitting way: the lowest index where ~hit is 0.
   cache_way_select #(
      .NUM_WAYS (NUM_WAYS),
      .WaySize  (WaySize)
   ) u_hit_sel (
      .valid_i    (~hit),
      .fifo_ptr_i ('0),
      .way_o      (hit_way)
   );

   cache_way_select #(
      .NUM_WAYS (NUM_WAYS),
      .WaySize  (WaySize)
   ) u_fill_sel (
      .valid_i    (valid_q[set]),
      .fifo_ptr_i (fifo_ptr_q[set]),
      .way_o      (populate_way)
   );

   assign read_valid = |hit;
   assign read_data  = read_valid ? data_q[set][hit_way] : '0;

endmodule

// File: tb/tb_cache_mem.sv
module tb_cache_mem;
   import cache_pkg::*;

   localparam int unsigned NS = 4;
   localparam int unsigned NW = 2;
   localparam int unsigned TS = tag_size(32, NS, 32);

   logic          clk;
   logic          rst;
   logic [0:0]    write_way;
   logic [1:0]    set;
   logic [TS-1:0] tag;
   logic          write_enable;
   logic [31:0]   write_data;
   logic [31:0]   read_data;
   logic          read_valid;
   logic [0:0]    populate_way;

   int checks = 0;
   int errors = 0;
   bit check_en = 0;

   // Behavioural model of the storage.
   bit          m_valid [NS][NW];
   int unsigned m_tag   [NS][NW];
   int unsigned m_data  [NS][NW];
   int unsigned m_fifo  [NS];

   cache_mem #(
      .ADDR_SIZE  (32),
      .NUM_SETS   (NS),
      .NUM_WAYS   (NW),
      .BLOCK_SIZE (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .write_way    (write_way),
      .set          (set),
      .tag          (tag),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data    (read_data),
      .read_valid   (read_valid),
      .populate_way (populate_way)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < NS; s++) begin
            m_fifo[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
         end
      end else if (write_enable) begin
         m_valid[set][write_way] = 1;
         m_tag[set][write_way]   = tag;
         m_data[set][write_way]  = write_data;
         if (write_way == m_fifo[set]) m_fifo[set] = (m_fifo[set] + 1) % NW;
      end
   end

   task automatic model_lookup(input int s, input int unsigned t, output bit v,
                               output int unsigned d, output int unsigned p);
      v = 0; d = 0; p = m_fifo[s];
      for (int w = NW - 1; w >= 0; w--) begin
         if (m_valid[s][w] && m_tag[s][w] == t) begin v = 1; d = m_data[s][w]; end
         if (!m_valid[s][w]) p = w;
      end
   endtask

   always @(negedge clk) begin
      bit          ev;
      int unsigned ed, ep;
      if (check_en) begin
         model_lookup(int'(set), int'(tag), ev, ed, ep);
         checks++;
         if (read_valid !== ev || read_data !== ed || populate_way !== ep[0:0]) begin
            errors++;
            $display("FAIL model set=%0d tag=%h: got v=%b d=%h p=%0d, want v=%b d=%h p=%0d",
                     set, tag, read_valid, read_data, populate_way, ev, ed, ep);
         end
      end
   end

   // Directed check against hand-computed literals; call at posedge+2, returns at posedge+2.
   task automatic look(input int s, input int unsigned t, input bit ev, input int unsigned ed,
                       input int unsigned ep, input string name);
      set = s[1:0]; tag = t[TS-1:0]; write_enable = 0;
      @(negedge clk);
      checks++;
      if (read_valid !== ev || read_data !== ed || populate_way !== ep[0:0]) begin
         errors++;
         $display("FAIL %s: got v=%b d=%h p=%0d, want v=%b d=%h p=%0d",
                  name, read_valid, read_data, populate_way, ev, ed, ep);
      end
      @(posedge clk); #2;
   endtask

   task automatic wr(input int s, input int w, input int unsigned t, input int unsigned d);
      set = s[1:0]; write_way = w[0:0]; tag = t[TS-1:0]; write_data = d; write_enable = 1;
      @(posedge clk); #2;
      write_enable = 0;
   endtask

   initial begin
      int unsigned t_r, d_r, t2;
      rst = 0; write_enable = 0; write_way = 0; set = 0; tag = '0; write_data = 0;
      t_r = $urandom_range(0, 32'h000F_FFFF);
      d_r = $urandom;
      t2  = $urandom_range(0, 32'h07FF_FFFF);
      repeat (2) @(posedge clk);
      #2;
      check_en = 1;
      rst = 1;

      // Reset state.
      for (int s = 0; s < NS; s++) begin
         look(s, 0, 0, 0, 0, "reset_tag0");
         look(s, t2, 0, 0, 0, "reset_tagrand");
      end

      // Write presented: no bypass in the same cycle.
      set = 0; write_way = 0; tag = t_r[TS-1:0]; write_data = d_r; write_enable = 1;
      @(negedge clk);
      checks++;
      if (read_valid !== 1'b0 || populate_way !== 1'b0) begin
         errors++;
         $display("FAIL no_bypass: got v=%b p=%0d, want v=0 p=0", read_valid, populate_way);
      end
      @(posedge clk); #2;
      write_enable = 0;
      look(0, t_r + 1, 0, 0, 1, "miss_t_plus_1");
      look(0, t_r, 1, d_r, 1, "hit_t");

      // Fill order and round-robin pointer in set 1.
      wr(1, 0, 32'h100, 32'hA0A0_0001);
      look(1, 32'h100, 1, 32'hA0A0_0001, 1, "fill_way0");
      wr(1, 1, 32'h101, 32'hA0A0_0002);
      look(1, 32'h101, 1, 32'hA0A0_0002, 0, "fill_way1_full");
      wr(1, 1, 32'h102, 32'hA0A0_0003);
      look(1, 32'h101, 0, 0, 0, "rewrite_way1_ptr_held");
      wr(1, 0, 32'h103, 32'hA0A0_0004);
      look(1, 32'h103, 1, 32'hA0A0_0004, 1, "rewrite_way0_ptr_adv");

      // Set isolation.
      wr(2, 0, 32'h5, 32'h0000_0055);
      look(3, 32'h5, 0, 0, 0, "iso_set3_miss");
      look(2, 32'h5, 1, 32'h55, 1, "iso_set2_hit");

      // Two ways in one set, then overwrite.
      wr(3, 0, 32'hA, 32'h11);
      wr(3, 1, 32'hB, 32'h22);
      look(3, 32'hA, 1, 32'h11, 0, "two_way_a");
      look(3, 32'hB, 1, 32'h22, 0, "two_way_b");
      wr(3, 0, 32'hC, 32'h33);
      look(3, 32'hA, 0, 0, 1, "overwrite_a_miss");
      look(3, 32'hC, 1, 32'h33, 1, "overwrite_c_hit");

      // Duplicate tag: lowest way wins.
      wr(0, 1, t_r, 32'hDEAD_BEEF);
      look(0, t_r, 1, d_r, 0, "dup_lowest_wins");

      // Reset together with a write: write is dropped, everything invalid.
      rst = 0;
      wr(2, 1, 32'h77, 32'h77);
      rst = 1;
      look(2, 32'h77, 0, 0, 0, "rst_drops_write");
      look(2, 32'h5, 0, 0, 0, "rst_clears_set2");
      for (int s = 0; s < NS; s++) look(s, 32'hC, 0, 0, 0, "rst_all_sets");

      check_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
